// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: widths, special opcodes and
// the fetch-stage state encoding.
package cpu_pkg;

    localparam int          PC_W      = 16;
    localparam logic [3:0]  OP_HLT    = 4'hF;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks an instruction response which arrived while
// fetch was stalled. Only instantiated when FETCH_SKID_EN is defined.
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [15:0] data_i,
    output logic        valid_o,
    output logic [15:0] data_o
);

    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;

    // A clear (redirect or drain) always beats a load.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instruction memory and writes IF/ID.
// Define FETCH_SKID_EN to buffer responses that arrive under stall instead of refetching.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter logic [PC_W-1:0] PC_STEP  = 16'd2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc_plus2,
    output logic            if_id_valid,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_plus2_q, pc_plus2_d, pc_next, req_addr;
    logic [15:0]     instr_q, instr_d, deliver_instr;
    logic            valid_q, valid_d, discard_q, discard_d, req, deliver;

`ifdef FETCH_SKID_EN
    logic        skid_valid, skid_load, skid_clear;
    logic [15:0] skid_data;

    fetch_skid_buf u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (imem_rdata),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );
`endif

    assign pc_next = pc_q + PC_STEP;

    // Priority: redirect, then stall, then normal issue/accept. A delivered
    // instruction (from memory or the skid buffer) chains the next request
    // in the same cycle unless it is HLT.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        pc_plus2_d    = pc_plus2_q;
        valid_d       = valid_q;
        discard_d     = discard_q;
        req           = 1'b0;
        req_addr      = pc_q;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
`ifdef FETCH_SKID_EN
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
`endif
        if (branch_taken) begin
            pc_d      = branch_target;
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            state_d   = ISSUE;
            discard_d = (state_q == WAIT || discard_q) && !imem_valid;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else if (stall) begin
            if (state_q == WAIT && imem_valid) begin
                state_d = ISSUE;
`ifdef FETCH_SKID_EN
                skid_load = 1'b1;
`endif
            end else if (state_q == ISSUE && discard_q && imem_valid) begin
                discard_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
            case (state_q)
                ISSUE: begin
`ifdef FETCH_SKID_EN
                    if (skid_valid) begin
                        deliver       = 1'b1;
                        deliver_instr = skid_data;
                        skid_clear    = 1'b1;
                    end else
`endif
                    if (discard_q) begin
                        if (imem_valid) discard_d = 1'b0;
                    end else begin
                        req     = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT:    if (imem_valid) deliver = 1'b1;
                default: ;
            endcase
            if (deliver) begin
                instr_d    = deliver_instr;
                pc_plus2_d = pc_next;
                valid_d    = 1'b1;
                pc_d       = pc_next;
                if (deliver_instr[15:12] == OP_HLT) begin
                    state_d = HALTED;
                end else begin
                    req      = 1'b1;
                    req_addr = pc_next;
                    state_d  = WAIT;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
            discard_q  <= discard_d;
        end
    end

    // The request strobe is gated so nothing is issued while reset is held.
    assign imem_req       = rst & req;
    assign imem_addr      = req_addr;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus2 = pc_plus2_q;
    assign if_id_valid    = valid_q;
    assign pc             = pc_q;
    assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queued expectations for request addresses and IF/ID
// contents, plus directed checks for reset, stall, redirect, halt and wrap.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [15:0] branch_target;
    logic        imem_req, imem_valid, if_id_valid, halted;
    logic [15:0] imem_addr, imem_rdata, if_id_instr, if_id_pc_plus2, pc;

    logic        req2, valid2, ifv2, halted2;
    logic [15:0] addr2, instr2, pcp2, pc2;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] reqQ[$];
    logic [31:0] ifidQ[$];

    logic [15:0] memArr [0:255];
    int          memLat;
    int          memCnt;
    logic        memPend;
    logic [15:0] memAddrQ;

    logic        prevValid;
    logic [31:0] prevWord;
    logic [15:0] expAddr;
    logic [31:0] expWord;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_valid     (imem_valid),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .pc             (pc),
        .halted         (halted)
    );

    fetch_stage #(.RESET_PC(16'hFFFE), .PC_STEP(16'd2)) dutWrap (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_valid     (valid2),
        .imem_rdata     (16'h1000),
        .if_id_instr    (instr2),
        .if_id_pc_plus2 (pcp2),
        .if_id_valid    (ifv2),
        .pc             (pc2),
        .halted         (halted2)
    );

    // Memory with programmable latency; at most one request in flight.
    assign imem_valid = memPend && (memCnt == 0);
    assign imem_rdata = imem_valid ? memArr[memAddrQ[8:1]] : 16'hDEAD;

    always @(posedge clk) begin
        if (memPend && memCnt > 0) memCnt <= memCnt - 1;
        else if (memPend) memPend <= 1'b0;
        if (imem_req) begin
            memPend  <= 1'b1;
            memAddrQ <= imem_addr;
            memCnt   <= memLat - 1;
        end
        valid2 <= req2;
    end

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [15:0] t);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
    endtask

    task automatic waitIfid(input logic [15:0] instr, input int maxCycles, output int used);
        used = 0;
        while (used < maxCycles && !(if_id_valid === 1'b1 && if_id_instr === instr)) begin
            @(posedge clk); #1;
            used++;
        end
        checks++;
        assert (if_id_valid === 1'b1 && if_id_instr === instr) else begin
            failures++;
            $error("[TB] FAIL wait_ifid observed=%h expected=%h", if_id_instr, instr);
        end
    endtask

    task automatic waitHalted(input int maxCycles);
        int n = 0;
        while (n < maxCycles && halted !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        assert (halted === 1'b1) else begin
            failures++;
            $error("[TB] FAIL wait_halted observed=%b expected=1", halted);
        end
    endtask

    // Every request and every newly loaded IF/ID entry is matched in order.
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            if (reqQ.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL req_unexpected observed=%h expected=none", imem_addr);
            end else begin
                expAddr = reqQ.pop_front();
                checkOutput("req_addr", imem_addr, expAddr);
            end
        end
        if (if_id_valid === 1'b1 && (!prevValid || {if_id_instr, if_id_pc_plus2} != prevWord)) begin
            if (ifidQ.size() == 0) begin
                checks++;
                failures++;
                $error("[TB] FAIL ifid_unexpected observed=%h expected=none", if_id_instr);
            end else begin
                expWord = ifidQ.pop_front();
                checkOutput("ifid_instr", if_id_instr, expWord[31:16]);
                checkOutput("ifid_pc_plus2", if_id_pc_plus2, expWord[15:0]);
            end
        end
        prevValid = (if_id_valid === 1'b1);
        prevWord  = {if_id_instr, if_id_pc_plus2};
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int used;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        memLat = 1; memCnt = 0; memPend = 1'b0; memAddrQ = 16'h0000;
        valid2 = 1'b0; prevValid = 1'b0; prevWord = '0;
        for (int i = 0; i < 256; i++) memArr[i] = 16'h0100 + 16'(i);
        memArr[8'h00] = 16'h1234; memArr[8'h01] = 16'h2345;
        memArr[8'h02] = 16'h3456; memArr[8'h03] = 16'h4567;
        memArr[8'h20] = 16'h7001; memArr[8'h21] = 16'h8002;
        memArr[8'h08] = 16'hF000;
        memArr[8'h10] = 16'h9ABC; memArr[8'h11] = 16'hF000;

        #3;
        checkOutput("rst_pc", pc, 16'h0000);
        checkOutput("rst_req", {15'd0, imem_req}, 16'd0);
        checkOutput("rst_addr", imem_addr, 16'h0000);
        checkOutput("rst_instr", if_id_instr, 16'h0000);
        checkOutput("rst_pcp2", if_id_pc_plus2, 16'h0000);
        checkOutput("rst_valid", {15'd0, if_id_valid}, 16'd0);
        checkOutput("rst_halted", {15'd0, halted}, 16'd0);
        @(posedge clk); @(posedge clk); #1;

        reqQ.push_back(16'h0000); reqQ.push_back(16'h0002); reqQ.push_back(16'h0004);
`ifndef FETCH_SKID_EN
        reqQ.push_back(16'h0004);
`endif
        reqQ.push_back(16'h0006);
        ifidQ.push_back({16'h1234, 16'h0002});
        ifidQ.push_back({16'h2345, 16'h0004});
        ifidQ.push_back({16'h3456, 16'h0006});
        rst = 1'b1;
        #1;
        checkOutput("wrap_req0", {15'd0, req2}, 16'd1);
        checkOutput("wrap_addr0", addr2, 16'hFFFE);
        @(posedge clk); #1;
        checkOutput("wrap_req1", {15'd0, req2}, 16'd1);
        checkOutput("wrap_addr1", addr2, 16'h0000);
        waitIfid(16'h2345, 10, used);

        // The 0x0004 response lands during the first stalled cycle.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        @(posedge clk); #1;
        checkOutput("stall_instr", if_id_instr, 16'h2345);
        checkOutput("stall_pcp2", if_id_pc_plus2, 16'h0004);
        checkOutput("stall_valid", {15'd0, if_id_valid}, 16'd1);
        checkOutput("stall_pc", pc, 16'h0004);
        checkOutput("stall_req", {15'd0, imem_req}, 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        memLat = 3;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        waitIfid(16'h3456, 12, used);
`ifdef FETCH_SKID_EN
        checkOutput("unstall_cycles", 16'(used), 16'd1);
`else
        checkOutput("unstall_cycles", 16'(used), 16'd4);
`endif

        // Redirect while the 0x0006 request is still in flight.
        reqQ.push_back(16'h0040); reqQ.push_back(16'h0042);
        ifidQ.push_back({16'h7001, 16'h0042});
        memLat = 1;
        applyStimulus(1'b0, 1'b1, 16'h0040);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("br_instr", if_id_instr, 16'h0000);
        checkOutput("br_valid", {15'd0, if_id_valid}, 16'd0);
        checkOutput("br_pc", pc, 16'h0040);
        waitIfid(16'h7001, 12, used);

        reqQ.push_back(16'h0010);
        ifidQ.push_back({16'hF000, 16'h0012});
        applyStimulus(1'b0, 1'b1, 16'h0010);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        waitHalted(10);
        checkOutput("hlt_instr", if_id_instr, 16'hF000);
        checkOutput("hlt_pcp2", if_id_pc_plus2, 16'h0012);
        checkOutput("hlt_pc", pc, 16'h0012);
        repeat (4) begin @(posedge clk); #1; end
        checkOutput("hlt_hold", {15'd0, halted}, 16'd1);
        checkOutput("hlt_hold_pc", pc, 16'h0012);
        checkOutput("hlt_no_req", {15'd0, imem_req}, 16'd0);

        reqQ.push_back(16'h0020); reqQ.push_back(16'h0022);
        ifidQ.push_back({16'h9ABC, 16'h0022});
        ifidQ.push_back({16'hF000, 16'h0024});
        applyStimulus(1'b0, 1'b1, 16'h0020);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("resume_halted", {15'd0, halted}, 16'd0);
        checkOutput("resume_pc", pc, 16'h0020);
        waitHalted(10);
        checkOutput("resume_hlt_pc", pc, 16'h0024);

        // Reset asserted mid-cycle while stalled must act without a clock edge.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_pc", pc, 16'h0000);
        checkOutput("arst_instr", if_id_instr, 16'h0000);
        checkOutput("arst_pcp2", if_id_pc_plus2, 16'h0000);
        checkOutput("arst_valid", {15'd0, if_id_valid}, 16'd0);
        checkOutput("arst_halted", {15'd0, halted}, 16'd0);
        checkOutput("arst_req", {15'd0, imem_req}, 16'd0);
        checkOutput("arst_addr", imem_addr, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("post_rst_stalled_req", {15'd0, imem_req}, 16'd0);
        checkOutput("reqQ_left", 16'(reqQ.size()), 16'd0);
        checkOutput("ifidQ_left", 16'(ifidQ.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
